tile_map_ram: RTL and testbench

TILE_MAP_RAM -- requirements
Module: tile_map_ram

---
 rtl/tile_map_ram_if.sv | 37 +++
 rtl/tile_map_ram.sv | 151 +++++++++++++++
 tb/tb_tile_map_ram.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_map_ram_if.sv
// Bus bundle for tile_map_ram: scroll/vsync, video lookup, CPU access and fill control.
// The slave side is the RAM; the master side drives requests.
interface tile_map_ram_if #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 5
);
    logic                     vsync;
    logic [COL_W-1:0]         scroll_x;
    logic [ROW_W-1:0]         scroll_y;
    logic                     vid_req;
    logic [COL_W-1:0]         vid_col;
    logic [ROW_W-1:0]         vid_row;
    logic                     vid_valid;
    logic [DATA_W-1:0]        vid_tile;
    logic                     cpu_valid;
    logic                     cpu_we;
    logic [COL_W+ROW_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]        cpu_wdata;
    logic                     cpu_ready;
    logic [DATA_W-1:0]        cpu_rdata;
    logic                     fill_start;
    logic [DATA_W-1:0]        fill_value;
    logic                     fill_busy;

    modport slave (
        input  vsync, scroll_x, scroll_y, vid_req, vid_col, vid_row,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, fill_start, fill_value,
        output vid_valid, vid_tile, cpu_ready, cpu_rdata, fill_busy
    );

    modport master (
        output vsync, scroll_x, scroll_y, vid_req, vid_col, vid_row,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, fill_start, fill_value,
        input  vid_valid, vid_tile, cpu_ready, cpu_rdata, fill_busy
    );
endinterface

// File: rtl/tile_map_ram.sv
// Scrolling tile map: single-port word array shared by a 2-stage video lookup,
// a whole-map fill engine and a CPU port, arbitrated video > fill > CPU.
//
// state  | meaning
// C_IDLE | waiting for a CPU request while the array port is free
// C_ACK  | access done last cycle; cpu_ready pulse, rdata valid
module tile_map_ram #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 5
) (
    input  logic          clk,
    input  logic          reset,
    tile_map_ram_if.slave bus
);
    localparam int AW    = COL_W + ROW_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {C_IDLE, C_ACK} cpu_state_e;

    cpu_state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [COL_W-1:0]  scr_x_q;
    logic [ROW_W-1:0]  scr_y_q;
    logic              vpipe_q;
    logic [AW-1:0]     vaddr_q;
    logic              vid_valid_q;
    logic [DATA_W-1:0] vid_tile_q;
    logic              fill_busy_q;
    logic [AW-1:0]     fill_addr_q;
    logic [DATA_W-1:0] fill_val_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic              cpu_grant;
    logic              fill_wr;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [COL_W-1:0]  vcol_sum;
    logic [ROW_W-1:0]  vrow_sum;

    // Carries dropped on purpose so the map wraps on both axes.
    assign vcol_sum = bus.vid_col + scr_x_q;
    assign vrow_sum = bus.vid_row + scr_y_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scr_x_q <= '0;
            scr_y_q <= '0;
        end else if (bus.vsync) begin
            scr_x_q <= bus.scroll_x;
            scr_y_q <= bus.scroll_y;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vpipe_q     <= 1'b0;
            vaddr_q     <= '0;
            vid_valid_q <= 1'b0;
            vid_tile_q  <= '0;
        end else begin
            vpipe_q     <= bus.vid_req;
            vid_valid_q <= vpipe_q;
            if (bus.vid_req) begin
                vaddr_q <= {vrow_sum, vcol_sum};
            end
            if (vpipe_q) begin
                vid_tile_q <= mem[mem_addr];
            end
        end
    end

    // The video access happens in the cycle after vid_req, so a pending video
    // access (vpipe_q) blocks both fill and CPU.
    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        fill_wr   = fill_busy_q && !vpipe_q;
        case (state_q)
            C_IDLE: begin
                if (bus.cpu_valid && !bus.vid_req && !vpipe_q && !fill_busy_q) begin
                    cpu_grant = 1'b1;
                    state_d   = C_ACK;
                end
            end
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase

        mem_addr  = bus.cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = bus.cpu_wdata;
        if (vpipe_q) begin
            mem_addr = vaddr_q;
        end else if (fill_wr) begin
            mem_addr  = fill_addr_q;
            mem_we    = 1'b1;
            mem_wdata = fill_val_q;
        end else if (cpu_grant) begin
            mem_we = bus.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= C_IDLE;
            cpu_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (cpu_grant && !bus.cpu_we) begin
                cpu_rdata_q <= mem[mem_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_busy_q <= 1'b0;
            fill_addr_q <= '0;
            fill_val_q  <= '0;
        end else if (!fill_busy_q) begin
            if (bus.fill_start) begin
                fill_busy_q <= 1'b1;
                fill_addr_q <= '0;
                fill_val_q  <= bus.fill_value;
            end
        end else if (fill_wr) begin
            if (fill_addr_q == {AW{1'b1}}) begin
                fill_busy_q <= 1'b0;
                fill_addr_q <= '0;
            end else begin
                fill_addr_q <= fill_addr_q + AW'(1);
            end
        end
    end

    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_tile  = vid_tile_q;
    assign bus.cpu_ready = (state_q == C_ACK);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.fill_busy = fill_busy_q;
endmodule

// File: tb/tb_tile_map_ram.sv
// Scoreboard bench for tile_map_ram: stimulus pushes expected video/CPU responses,
// a negedge monitor pops and compares them whenever vid_valid or cpu_ready is seen.
module tb_tile_map_ram;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tile_map_ram_if #(.DATA_W(8), .COL_W(6), .ROW_W(5)) bus ();

    tile_map_ram #(.DATA_W(8), .COL_W(6), .ROW_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] tile;
        int         due;
    } vexp_t;

    vexp_t      vid_q[$];
    logic [7:0] cpu_q[$];
    logic [7:0] model [2048];
    logic [5:0] scr_x = '0;
    logic [4:0] scr_y = '0;
    logic [7:0] last_rd = '0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         vid_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        vexp_t      e;
        logic [7:0] d;
        if (!reset && bus.vid_valid) begin
            vid_seen++;
            if (vid_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vid_unexpected: vid_valid=1 tile=0x%0h with no lookup pending", bus.vid_tile);
            end else begin
                e = vid_q.pop_front();
                chk("vid_tile", bus.vid_tile, e.tile);
                chk("vid_latency", cyc, e.due);
            end
        end
        if (!reset && bus.cpu_ready) begin
            if (cpu_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cpu_unexpected: cpu_ready=1 with no access pending");
            end else begin
                d = cpu_q.pop_front();
                chk("cpu_rdata", bus.cpu_rdata, d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] vaddr(input logic [5:0] c, input logic [4:0] r);
        logic [5:0] cc;
        logic [4:0] rr;
        cc = c + scr_x;
        rr = r + scr_y;
        return {rr, cc};
    endfunction

    task automatic vid_push(input logic [5:0] c, input logic [4:0] r, input logic [7:0] exp);
        bus.vid_req = 1'b1;
        bus.vid_col = c;
        bus.vid_row = r;
        vid_q.push_back('{tile: exp, due: cyc + 2});
    endtask

    task automatic set_scroll(input logic [5:0] x, input logic [4:0] y);
        bus.vsync    = 1'b1;
        bus.scroll_x = x;
        bus.scroll_y = y;
        tick();
        bus.vsync = 1'b0;
        scr_x = x;
        scr_y = y;
    endtask

    task automatic cpu_op(input logic we, input logic [10:0] addr, input logic [7:0] wd, output int lat);
        if (we) begin
            cpu_q.push_back(last_rd);
            model[addr] = wd;
        end else begin
            cpu_q.push_back(model[addr]);
            last_rd = model[addr];
        end
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cpu_ready && lat < 50);
        if (!bus.cpu_ready) chk("cpu_ready_timeout", bus.cpu_ready, 1);
        bus.cpu_valid = 1'b0;
        tick();
        chk("cpu_ready_width", bus.cpu_ready, 0);
    endtask

    // Lookups at iterations vid_at.. alternate addr 0 (already filled) and addr 2047 (not yet filled); scroll must be 0.
    task automatic fill_run(input logic [7:0] val, input int vid_at, input int vid_n,
                            input int restart_at, output int busy);
        logic [7:0] old_last;
        old_last = model[2047];
        bus.fill_start = 1'b1;
        bus.fill_value = val;
        tick();
        bus.fill_start = 1'b0;
        bus.fill_value = ~val;
        busy = 0;
        while (bus.fill_busy && busy < 3000) begin
            busy++;
            bus.vid_req = 1'b0;
            if (busy >= vid_at && busy < vid_at + vid_n) begin
                if (((busy - vid_at) % 2) == 0) vid_push(6'd0, 5'd0, val);
                else vid_push(6'd63, 5'd31, old_last);
            end
            bus.fill_start = (busy == restart_at);
            tick();
        end
        bus.vid_req    = 1'b0;
        bus.fill_start = 1'b0;
        for (int i = 0; i < 2048; i++) model[i] = val;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int busy;
        int seen0;

        reset          = 1'b1;
        bus.vsync      = 1'b0;
        bus.scroll_x   = '0;
        bus.scroll_y   = '0;
        bus.vid_req    = 1'b0;
        bus.vid_col    = '0;
        bus.vid_row    = '0;
        bus.cpu_valid  = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.fill_start = 1'b0;
        bus.fill_value = '0;
        for (int i = 0; i < 2048; i++) model[i] = 'x;
        #2;
        chk("rst_vid_valid", bus.vid_valid, 0);
        chk("rst_vid_tile", bus.vid_tile, 0);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_fill_busy", bus.fill_busy, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // CPU write then read-back
        cpu_op(1'b1, 11'h045, 8'h2A, lat);
        chk("cpu_wr_latency", lat, 1);
        cpu_op(1'b0, 11'h045, 8'h00, lat);
        chk("cpu_rd_latency", lat, 1);

        // Full fill, no video traffic
        fill_run(8'hFF, 0, 0, -1, busy);
        chk("fill_busy_cycles", busy, 2048);
        cpu_op(1'b0, 11'd0, 8'h00, lat);
        cpu_op(1'b0, 11'd1023, 8'h00, lat);
        cpu_op(1'b0, 11'd2047, 8'h00, lat);

        // Scroll and wrap
        cpu_op(1'b1, 11'h000, 8'h11, lat);
        cpu_op(1'b1, 11'h041, 8'h22, lat);
        vid_push(6'd1, 5'd1, model[vaddr(6'd1, 5'd1)]);
        tick();
        bus.vid_req = 1'b0;
        set_scroll(6'd63, 5'd31);
        vid_push(6'd1, 5'd1, model[vaddr(6'd1, 5'd1)]);
        tick();
        bus.scroll_x = 6'd0;
        vid_push(6'd2, 5'd1, model[vaddr(6'd2, 5'd1)]);
        tick();
        bus.vid_req = 1'b0;
        set_scroll(6'd0, 5'd0);

        // Video holds off a pending CPU read
        for (int i = 0; i < 4; i++) cpu_op(1'b1, {5'd2, 6'(i)}, 8'h30 + 8'(i), lat);
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 11'h082;
        cpu_q.push_back(model[11'h082]);
        last_rd = model[11'h082];
        seen0 = vid_seen;
        for (int i = 0; i < 10; i++) begin
            vid_push(6'(i), 5'd2, model[vaddr(6'(i), 5'd2)]);
            tick();
            chk("cpu_ready_during_vid", bus.cpu_ready, 0);
        end
        bus.vid_req = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.cpu_ready && lat < 20);
        chk("cpu_ready_after_vid", lat, 2);
        bus.cpu_valid = 1'b0;
        tick();
        chk("cpu_ready_width", bus.cpu_ready, 0);
        tick();
        chk("vid_valid_count", vid_seen - seen0, 10);

        // Fill stalled by 5 video cycles, with an ignored restart
        fill_run(8'h5A, 100, 5, 500, busy);
        chk("fill_busy_stalled", busy, 2053);
        cpu_op(1'b0, 11'd2047, 8'h00, lat);
        cpu_op(1'b0, 11'd1024, 8'h00, lat);

        // Reset mid-fill and mid-video-pipeline
        set_scroll(6'd5, 5'd3);
        bus.fill_start = 1'b1;
        bus.fill_value = 8'h77;
        tick();
        bus.fill_start = 1'b0;
        repeat (50) tick();
        for (int i = 0; i < 3; i++) begin
            vid_push(6'(i), 5'd29, 8'h77);
            tick();
        end
        bus.vid_req = 1'b0;
        chk("pre_reset_vid_valid", bus.vid_valid, 1);
        chk("pre_reset_fill_busy", bus.fill_busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("async_vid_valid", bus.vid_valid, 0);
        chk("async_vid_tile", bus.vid_tile, 0);
        chk("async_cpu_ready", bus.cpu_ready, 0);
        chk("async_cpu_rdata", bus.cpu_rdata, 0);
        chk("async_fill_busy", bus.fill_busy, 0);
        vid_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        scr_x   = '0;
        scr_y   = '0;
        last_rd = '0;
        tick();

        fill_run(8'h33, 2, 1, -1, busy);
        chk("fill_after_reset", busy, 2049);
        cpu_op(1'b0, 11'h400, 8'h00, lat);

        repeat (4) tick();
        chk("vid_q_drained", vid_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
